spi_master_param: RTL and testbench



---
 rtl/spi_master_param.sv | 143 ++++++++++++++
 tb/tb_spi_master_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: divider-generated SCLK, all four modes, MSB/LSB-first,
// and multi-word bursts that keep SS low until a word tagged `last` completes.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 750,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              last,
    input  logic [DATA_W-1:0] DIN,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic              SS,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] DOUT
);
    // state | meaning
    // IDLE  | SS high, waiting for start
    // SETUP | SS low, half-period before the first SCLK edge
    // XFER  | 2*DATA_W SCLK toggles, shift and sample
    // HOLD  | word done, SS still low, waiting for the next burst word
    // GAP   | half-period spacing between burst words
    // TAIL  | half-period SS hold, then half-period deselect
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(2*DATA_W+1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV-1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*DATA_W-1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP, S_TAIL} state_t;
    state_t state, state_nx;

    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] tx, rx, dout_r, tx_sh, rx_nx;
    logic last_r, sclk_r, mosi_r, done_r;
    logic active, tick, accept, leading, final_tg, sample, shift;
    logic tx_first, tx_sh_first, din_first, busy_c, ss_c;

    assign active   = (state == S_SETUP) || (state == S_XFER) || (state == S_GAP) || (state == S_TAIL);
    assign tick     = active && (div == DIV_MAX);
    assign accept   = start && ((state == S_IDLE) || (state == S_HOLD));
    assign leading  = ~cnt[0];
    assign final_tg = (cnt == CNT_LAST);
    assign sample   = (state == S_XFER) && tick && ((CPHA == 0) ? leading : !leading);
    assign shift    = (state == S_XFER) && tick && ((CPHA == 0) ? (!leading && !final_tg) : leading);

    assign tx_sh       = (MSB_FIRST != 0) ? {tx[DATA_W-2:0], 1'b0} : {1'b0, tx[DATA_W-1:1]};
    assign rx_nx       = (MSB_FIRST != 0) ? {rx[DATA_W-2:0], MISO} : {MISO, rx[DATA_W-1:1]};
    assign tx_first    = (MSB_FIRST != 0) ? tx[DATA_W-1] : tx[0];
    assign tx_sh_first = (MSB_FIRST != 0) ? tx[DATA_W-2] : tx[1];
    assign din_first   = (MSB_FIRST != 0) ? DIN[DATA_W-1] : DIN[0];

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_c   = 1'b1;
        ss_c     = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                ss_c   = 1'b1;
                if (start) state_nx = S_SETUP;
            end
            S_SETUP: if (tick) state_nx = S_XFER;
            S_XFER:  if (tick && final_tg) state_nx = last_r ? S_TAIL : S_HOLD;
            S_HOLD: begin
                busy_c = 1'b0;
                if (start) state_nx = S_GAP;
            end
            S_GAP:   if (tick) state_nx = S_XFER;
            S_TAIL: begin
                ss_c = (cnt != '0);
                if (tick && (cnt == CNT_ONE)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div    <= '0;
            cnt    <= '0;
            tx     <= '0;
            rx     <= '0;
            dout_r <= '0;
            last_r <= 1'b0;
            sclk_r <= (CPOL != 0);
            mosi_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;

            if (state_nx != state || tick || !active) div <= '0;
            else                                      div <= div + 1'b1;

            if (state_nx != state)                              cnt <= '0;
            else if (tick && (state == S_XFER || state == S_TAIL)) cnt <= cnt + 1'b1;

            if (accept) begin
                tx     <= DIN;
                rx     <= '0;
                last_r <= last;
            end

            if (state == S_XFER && tick) sclk_r <= ~sclk_r;
            if (sample) rx <= rx_nx;
            if (shift)  tx <= tx_sh;

            // Final toggle: capture includes the bit sampled on this very edge (CPHA=1).
            if (state == S_XFER && tick && final_tg) begin
                dout_r <= sample ? rx_nx : rx;
                done_r <= 1'b1;
            end

            case (state)
                S_SETUP, S_GAP: mosi_r <= (CPHA == 0) ? tx_first : 1'b0;
                S_XFER: begin
                    if (tick && final_tg) mosi_r <= 1'b0;
                    else if (shift)       mosi_r <= (CPHA == 0) ? tx_sh_first : tx_first;
                end
                default: mosi_r <= (accept && CPHA == 0) ? din_first : 1'b0;
            endcase
        end
    end

    assign SCLK = sclk_r;
    assign MOSI = mosi_r;
    assign DONE = done_r;
    assign DOUT = dout_r;
    assign BUSY = busy_c;
    assign SS   = ss_c;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: six instances cover modes, bit order,
// word width, bursts and mid-transfer reset.
module tb_spi_master_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    localparam logic [7:0] SLV_WORD = 8'h3C;

    // u0: 8-bit, div 2, mode 0, MSB first, loopback
    logic start0, last0, mosi0, sclk0, ss0, busy0, done0;
    logic [7:0] din0, dout0;
    // u1..u3: modes 1..3 against slave model
    logic start_m, last_m;
    logic [7:0] din_m;
    logic mosi1, sclk1, ss1, busy1, done1, miso1;
    logic mosi2, sclk2, ss2, busy2, done2, miso2;
    logic mosi3, sclk3, ss3, busy3, done3, miso3;
    logic [7:0] dout1, dout2, dout3;
    // u4: LSB first loopback
    logic start4, last4, mosi4, sclk4, ss4, busy4, done4;
    logic [7:0] din4, dout4;
    // u5: 12-bit, div 3, loopback
    logic start5, last5, mosi5, sclk5, ss5, busy5, done5;
    logic [11:0] din5, dout5;

    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .CLK(clk), .RST(rst), .start(start0), .last(last0), .DIN(din0), .MISO(mosi0),
        .MOSI(mosi0), .SCLK(sclk0), .SS(ss0), .BUSY(busy0), .DONE(done0), .DOUT(dout0));
    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(1), .MSB_FIRST(1)) u1 (
        .CLK(clk), .RST(rst), .start(start_m), .last(last_m), .DIN(din_m), .MISO(miso1),
        .MOSI(mosi1), .SCLK(sclk1), .SS(ss1), .BUSY(busy1), .DONE(done1), .DOUT(dout1));
    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) u2 (
        .CLK(clk), .RST(rst), .start(start_m), .last(last_m), .DIN(din_m), .MISO(miso2),
        .MOSI(mosi2), .SCLK(sclk2), .SS(ss2), .BUSY(busy2), .DONE(done2), .DOUT(dout2));
    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u3 (
        .CLK(clk), .RST(rst), .start(start_m), .last(last_m), .DIN(din_m), .MISO(miso3),
        .MOSI(mosi3), .SCLK(sclk3), .SS(ss3), .BUSY(busy3), .DONE(done3), .DOUT(dout3));
    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u4 (
        .CLK(clk), .RST(rst), .start(start4), .last(last4), .DIN(din4), .MISO(mosi4),
        .MOSI(mosi4), .SCLK(sclk4), .SS(ss4), .BUSY(busy4), .DONE(done4), .DOUT(dout4));
    spi_master_param #(.DATA_W(12), .CLK_DIV(3), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u5 (
        .CLK(clk), .RST(rst), .start(start5), .last(last5), .DIN(din5), .MISO(mosi5),
        .MOSI(mosi5), .SCLK(sclk5), .SS(ss5), .BUSY(busy5), .DONE(done5), .DOUT(dout5));

    // Slave: the correct bit is valid only in the half-period before the legal
    // sample edge; the inverted bit is driven before the illegal one.
    function automatic logic miso_f(input int tg, input int cpha);
        int k;
        k = tg / 2;
        if (k > 7) return 1'b0;
        return SLV_WORD[7-k] ^ ((cpha == 0) ? tg[0] : ~tg[0]);
    endfunction

    int tg1 = 0, tg2 = 0, tg3 = 0;
    logic sp1 = 1'b0, sp2 = 1'b1, sp3 = 1'b1;
    logic [7:0] srx1 = '0, srx2 = '0, srx3 = '0;
    assign miso1 = miso_f(tg1, 1);
    assign miso2 = miso_f(tg2, 0);
    assign miso3 = miso_f(tg3, 1);

    always @(sclk1 or ss1) begin
        if (ss1) tg1 = 0;
        else if (sclk1 !== sp1) begin
            tg1++;
            if (tg1 % 2 == 0) srx1 = {srx1[6:0], mosi1};
        end
        sp1 = sclk1;
    end
    always @(sclk2 or ss2) begin
        if (ss2) tg2 = 0;
        else if (sclk2 !== sp2) begin
            tg2++;
            if (tg2 % 2 == 1) srx2 = {srx2[6:0], mosi2};
        end
        sp2 = sclk2;
    end
    always @(sclk3 or ss3) begin
        if (ss3) tg3 = 0;
        else if (sclk3 !== sp3) begin
            tg3++;
            if (tg3 % 2 == 0) srx3 = {srx3[6:0], mosi3};
        end
        sp3 = sclk3;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        n_total++; if (ss0 !== 1'b1)   $display("FAIL rst_ss got %b want 1", ss0);      else n_pass++;
        n_total++; if (sclk0 !== 1'b0) $display("FAIL rst_sclk got %b want 0", sclk0);  else n_pass++;
        n_total++; if (mosi0 !== 1'b0) $display("FAIL rst_mosi got %b want 0", mosi0);  else n_pass++;
        n_total++; if (busy0 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy0);  else n_pass++;
        n_total++; if (done0 !== 1'b0) $display("FAIL rst_done got %b want 0", done0);  else n_pass++;
        n_total++; if (dout0 !== 8'h00) $display("FAIL rst_dout got %h want 00", dout0); else n_pass++;
        n_total++; if (sclk2 !== 1'b1) $display("FAIL rst_sclk_cpol1 got %b want 1", sclk2); else n_pass++;
    endtask

    task automatic test_mode0();
        int n, toggles, done_n, dcount;
        logic prev;
        logic [7:0] bits, dv;
        din0 = 8'hA5; last0 = 1'b1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 1; toggles = 0; done_n = 0; dcount = 0; bits = '0; dv = '0;
        n_total++; if (ss0 !== 1'b0)   $display("FAIL m0_ss_fall got %b want 0", ss0);  else n_pass++;
        n_total++; if (busy0 !== 1'b1) $display("FAIL m0_busy got %b want 1", busy0);   else n_pass++;
        prev = sclk0;
        while (!(dcount > 0 && !busy0 && ss0) && n < 200) begin
            cyc();
            n++;
            if (sclk0 !== prev) begin
                toggles++;
                if (sclk0 === 1'b1) bits = {bits[6:0], mosi0};
            end
            prev = sclk0;
            if (done0) begin dcount++; done_n = n; dv = dout0; end
        end
        n_total++; if (toggles != 16)  $display("FAIL m0_toggles got %0d want 16", toggles); else n_pass++;
        n_total++; if (bits !== 8'hA5) $display("FAIL m0_mosi_seq got %h want a5", bits);   else n_pass++;
        n_total++; if (done_n != 35)   $display("FAIL m0_done_cycle got %0d want 35", done_n); else n_pass++;
        n_total++; if (dv !== 8'hA5)   $display("FAIL m0_dout got %h want a5", dv);         else n_pass++;
        n_total++; if (dcount != 1)    $display("FAIL m0_done_count got %0d want 1", dcount); else n_pass++;
        n_total++; if (ss0 !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL m0_release got ss=%b busy=%b want ss=1 busy=0", ss0, busy0); else n_pass++;
    endtask

    task automatic test_modes();
        int n;
        logic g1, g2, g3;
        logic [7:0] d1, d2, d3;
        n_total++; if ({sclk1, sclk2, sclk3} !== 3'b011)
            $display("FAIL modes_sclk_idle_pre got %b want 011", {sclk1, sclk2, sclk3}); else n_pass++;
        din_m = 8'h96; last_m = 1'b1; start_m = 1'b1;
        cyc();
        start_m = 1'b0;
        n = 1; g1 = 0; g2 = 0; g3 = 0; d1 = '0; d2 = '0; d3 = '0;
        while (!(g1 && g2 && g3 && !busy1 && !busy2 && !busy3 && ss1 && ss2 && ss3) && n < 200) begin
            cyc();
            n++;
            if (done1) begin g1 = 1; d1 = dout1; end
            if (done2) begin g2 = 1; d2 = dout2; end
            if (done3) begin g3 = 1; d3 = dout3; end
        end
        n_total++; if (d1 !== 8'h3C) $display("FAIL mode1_dout got %h want 3c", d1); else n_pass++;
        n_total++; if (d2 !== 8'h3C) $display("FAIL mode2_dout got %h want 3c", d2); else n_pass++;
        n_total++; if (d3 !== 8'h3C) $display("FAIL mode3_dout got %h want 3c", d3); else n_pass++;
        n_total++; if (srx1 !== 8'h96) $display("FAIL mode1_slave_rx got %h want 96", srx1); else n_pass++;
        n_total++; if (srx2 !== 8'h96) $display("FAIL mode2_slave_rx got %h want 96", srx2); else n_pass++;
        n_total++; if (srx3 !== 8'h96) $display("FAIL mode3_slave_rx got %h want 96", srx3); else n_pass++;
        n_total++; if ({sclk1, sclk2, sclk3} !== 3'b011)
            $display("FAIL modes_sclk_idle_post got %b want 011", {sclk1, sclk2, sclk3}); else n_pass++;
    endtask

    task automatic test_lsb();
        int n, leads;
        logic prev, first_bit, got;
        logic [7:0] bits, dv;
        din4 = 8'h01; last4 = 1'b1; start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        n = 1; leads = 0; got = 0; first_bit = 1'b0; bits = '0; dv = '0;
        prev = sclk4;
        while (!(got && !busy4 && ss4) && n < 200) begin
            cyc();
            n++;
            if (sclk4 !== prev && sclk4 === 1'b1) begin
                if (leads == 0) first_bit = mosi4;
                leads++;
                bits = {mosi4, bits[7:1]};
            end
            prev = sclk4;
            if (done4) begin got = 1; dv = dout4; end
        end
        n_total++; if (first_bit !== 1'b1) $display("FAIL lsb_first_bit got %b want 1", first_bit); else n_pass++;
        n_total++; if (bits !== 8'h01) $display("FAIL lsb_mosi_seq got %h want 01", bits); else n_pass++;
        n_total++; if (dv !== 8'h01)   $display("FAIL lsb_dout got %h want 01", dv);       else n_pass++;
    endtask

    task automatic test_burst();
        logic [7:0] w[3];
        logic lst[3];
        logic [7:0] got[3];
        int n, idx, dcount, rises;
        logic prev_ss, early_high;
        w = '{8'h11, 8'h22, 8'h33};
        lst = '{1'b0, 1'b0, 1'b1};
        got = '{8'h00, 8'h00, 8'h00};
        din0 = w[0]; last0 = lst[0]; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 1; idx = 1; dcount = 0; rises = 0; early_high = 1'b0;
        prev_ss = ss0;
        while (!(dcount >= 3 && !busy0 && ss0) && n < 400) begin
            cyc();
            n++;
            start0 = 1'b0;
            if (ss0 && !prev_ss) rises++;
            prev_ss = ss0;
            if (done0) begin
                if (dcount < 3) got[dcount] = dout0;
                dcount++;
                if (idx < 3) begin
                    din0 = w[idx]; last0 = lst[idx]; start0 = 1'b1;
                    idx++;
                end
            end
            if (ss0 && dcount < 3) early_high = 1'b1;
        end
        n_total++; if (dcount != 3)      $display("FAIL burst_done_count got %0d want 3", dcount); else n_pass++;
        n_total++; if (got[0] !== 8'h11) $display("FAIL burst_w0 got %h want 11", got[0]); else n_pass++;
        n_total++; if (got[1] !== 8'h22) $display("FAIL burst_w1 got %h want 22", got[1]); else n_pass++;
        n_total++; if (got[2] !== 8'h33) $display("FAIL burst_w2 got %h want 33", got[2]); else n_pass++;
        n_total++; if (early_high !== 1'b0) $display("FAIL burst_ss_low got early_high=%b want 0", early_high); else n_pass++;
        n_total++; if (rises != 1)       $display("FAIL burst_ss_rises got %0d want 1", rises); else n_pass++;
    endtask

    task automatic test_wide();
        int n, toggles, dcount, done_n, extra;
        logic prev;
        logic [11:0] dv;
        din5 = 12'hABC; last5 = 1'b1; start5 = 1'b1;
        cyc();
        start5 = 1'b0;
        n = 1; toggles = 0; dcount = 0; done_n = 0; dv = '0;
        prev = sclk5;
        while (!(dcount > 0 && !busy5 && ss5) && n < 300) begin
            cyc();
            n++;
            start5 = 1'b0;
            if (n == 20) begin din5 = 12'h123; last5 = 1'b0; start5 = 1'b1; end
            if (sclk5 !== prev) toggles++;
            prev = sclk5;
            if (done5) begin dcount++; done_n = n; dv = dout5; end
        end
        start5 = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done5 || busy5 || !ss5) extra++;
        end
        n_total++; if (toggles != 24)   $display("FAIL wide_toggles got %0d want 24", toggles); else n_pass++;
        n_total++; if (dv !== 12'hABC)  $display("FAIL wide_dout got %h want abc", dv);       else n_pass++;
        n_total++; if (done_n != 76)    $display("FAIL wide_latency got %0d want 76", done_n); else n_pass++;
        n_total++; if (dcount != 1 || extra != 0)
            $display("FAIL wide_busy_start_ignored got dones=%0d activity=%0d want 1 and 0", dcount, extra); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int n, toggles, spurious;
        logic prev, got;
        logic [7:0] dv;
        din0 = 8'hFF; last0 = 1'b1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 1; toggles = 0;
        prev = sclk0;
        while (toggles < 5 && n < 100) begin
            cyc();
            n++;
            if (sclk0 !== prev) toggles++;
            prev = sclk0;
        end
        n_total++; if (toggles != 5) $display("FAIL rstmid_reach_toggle5 got %0d want 5", toggles); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_total++; if ({ss0, sclk0, busy0, done0} !== 4'b1000)
            $display("FAIL rstmid_ctrl got ss,sclk,busy,done=%b want 1000", {ss0, sclk0, busy0, done0}); else n_pass++;
        n_total++; if (dout0 !== 8'h00) $display("FAIL rstmid_dout got %h want 00", dout0); else n_pass++;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done0 || busy0) spurious++;
        end
        n_total++; if (spurious != 0) $display("FAIL rstmid_no_done got %0d want 0", spurious); else n_pass++;
        din0 = 8'h5A; last0 = 1'b1; start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        n = 1; got = 1'b0; dv = '0;
        while (!(got && !busy0 && ss0) && n < 200) begin
            cyc();
            n++;
            if (done0) begin got = 1'b1; dv = dout0; end
        end
        n_total++; if (dv !== 8'h5A) $display("FAIL rstmid_after_dout got %h want 5a", dv); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        start0 = 0; last0 = 0; din0 = '0;
        start_m = 0; last_m = 0; din_m = '0;
        start4 = 0; last4 = 0; din4 = '0;
        start5 = 0; last5 = 0; din5 = '0;
        @(negedge clk);
        test_reset();
        test_mode0();
        test_modes();
        test_lsb();
        test_burst();
        test_wide();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
